// File: rtl/mesh_term_rx.sv
// rtl/mesh_term_rx.sv - mesh terminal receive endpoint: router drain, address filter, local FIFO
module mesh_term_rx #(
   parameter int pckg_sz    = 40,
   parameter int fifo_depth = 4,
   parameter int ROWS       = 4,
   parameter int COLUMS     = 4,
   parameter int SELF_ROW   = 0,
   parameter int SELF_COL   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pndng,
   input  logic [pckg_sz-1:0] data_out,
   output logic               pop,
   output logic               rx_valid,
   output logic [pckg_sz-1:0] rx_data,
   input  logic               rx_ready,
   output logic               misroute,
   output logic [15:0]        pkt_cnt,
   output logic [15:0]        err_cnt,
   output logic               fifo_full
);

   localparam int AW = $clog2(fifo_depth);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

   state_t state, next_state;

   logic [pckg_sz-1:0] mem [fifo_depth];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      count, count_next;

   logic [3:0] id_row, id_col;
   logic       bcast, hit, wr_en, rd_en, miss;
   logic       unused_bits;

   assign id_row = data_out[pckg_sz-9 -: 4];
   assign id_col = data_out[pckg_sz-13 -: 4];
   assign bcast  = (id_row == 4'hF) && (id_col == 4'hF);
   assign hit    = ((id_row == 4'(SELF_ROW)) && (id_col == 4'(SELF_COL))) || bcast;

   // Routing fields other than the address are not inspected here.
   assign unused_bits = &{1'b0, data_out[pckg_sz-1 -: 8], data_out[pckg_sz-17:0],
                          (ROWS > 0), (COLUMS > 0)};

   // data_out is consumed at the end of the POP cycle, while pop is still asserted.
   assign wr_en    = (state == POP) && hit;
   assign miss     = (state == POP) && !hit;
   assign rx_valid = (count != '0);
   assign rd_en    = rx_valid && rx_ready;
   assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

   // Next-state: only IDLE looks at pndng and FIFO space, so one packet at most is in flight.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (pndng && (count < CW'(fifo_depth))) next_state = POP;
         POP:     next_state = SETTLE;
         SETTLE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // FIFO occupancy after this cycle's write and read.
   always_comb begin
      count_next = count;
      if (wr_en && !rd_en)
         count_next = count + CW'(1);
      else if (rd_en && !wr_en)
         count_next = count - CW'(1);
   end

   // State register; pop is registered from the next state so it is glitch-free.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         pop   <= 1'b0;
      end else begin
         state <= next_state;
         pop   <= (next_state == POP);
      end
   end

   // FIFO pointers, occupancy, status flags and saturating counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         fifo_full <= 1'b0;
         misroute  <= 1'b0;
         pkt_cnt   <= '0;
         err_cnt   <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count     <= count_next;
         fifo_full <= (count_next == CW'(fifo_depth));
         misroute  <= miss;
         if (wr_en && (pkt_cnt != 16'hFFFF)) pkt_cnt <= pkt_cnt + 16'd1;
         if (miss && (err_cnt != 16'hFFFF))  err_cnt <= err_cnt + 16'd1;
      end
   end

   // Storage array; contents are masked by rx_valid so it needs no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= data_out;
   end

endmodule
